sort_buf: RTL



---
 rtl/sort_buf_pkg.sv | 14 +
 rtl/sort_buf_cmp_unit.sv | 28 ++
 rtl/sort_buf.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sort_buf_pkg.sv
// Shared definitions for the sort_buf batch sorter: FSM state encoding and
// default operand width / batch depth.
package sort_buf_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/sort_buf_cmp_unit.sv
// Combinational signed compare of two two's-complement operands.
// Exactly one of gt/eq/lt is high; operand sign bits are exported too.
module cmp_unit
  import sort_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             sign_a,
  output logic             sign_b
);

  always_comb begin
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1];
    eq     = (a == b);
    // Mixed signs: the negative operand is smaller. Same sign: raw bits
    // order correctly as unsigned magnitude.
    if (sign_a != sign_b) lt = sign_a;
    else                  lt = (a < b);
    gt = !eq && !lt;
  end

endmodule

// File: rtl/sort_buf.sv
// Batch sorter: loads DEPTH signed values, bubble-sorts them ascending with
// one compare per cycle, then drains them in order through a valid/ready port.
module sort_buf
  import sort_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [WIDTH-1:0]    out_data,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       sort_done,
  output logic [$clog2(DEPTH)-1:0]   passes
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, idx_q, pass_q, passes_q;
  logic             swapped_q;
  logic [PW-1:0]    idx_nx;

  logic load_fire, out_fire, pass_end, sort_exit;
  logic cmp_gt, cmp_eq, cmp_lt, sign_a, sign_b;

  assign idx_nx = idx_q + 1'b1;

  cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .a      (mem_q[idx_q]),
    .b      (mem_q[idx_nx]),
    .gt     (cmp_gt),
    .eq     (cmp_eq),
    .lt     (cmp_lt),
    .sign_a (sign_a),
    .sign_b (sign_b)
  );

  // Only gt drives the swap; the remaining flags are observable on the
  // compare unit but have no consumer here.
  logic cmp_unused;
  assign cmp_unused = ^{cmp_eq, cmp_lt, sign_a, sign_b};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    sort_done = 1'b0;
    load_fire = 1'b0;
    out_fire  = 1'b0;
    pass_end  = 1'b0;
    sort_exit = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready  = 1'b1;
        load_fire = in_valid;
        if (in_valid && wr_ptr_q == LAST_PTR) state_d = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) begin
          pass_end = 1'b1;
          // A clean pass (including this compare) or the last possible
          // pass ends the sort.
          if ((!swapped_q && !cmp_gt) || pass_q == LAST_PASS) begin
            sort_exit = 1'b1;
            sort_done = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_fire  = out_ready;
        if (out_ready && rd_ptr_q == LAST_PTR) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: the entry array is small and its contents are visible on
  // out_data, so it is cleared on reset along with the control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      passes_q  <= '0;
      swapped_q <= 1'b0;
    end else begin
      if (load_fire) begin
        mem_q[wr_ptr_q] <= in_data;
        if (wr_ptr_q != LAST_PTR) wr_ptr_q <= wr_ptr_q + 1'b1;
      end

      if (busy) begin
        if (cmp_gt) begin
          mem_q[idx_q]  <= mem_q[idx_nx];
          mem_q[idx_nx] <= mem_q[idx_q];
          swapped_q     <= 1'b1;
        end
        if (pass_end) begin
          idx_q     <= '0;
          swapped_q <= 1'b0;
          pass_q    <= pass_q + 1'b1;
        end else begin
          idx_q <= idx_nx;
        end
        if (sort_exit) begin
          passes_q <= pass_q + 1'b1;
          pass_q   <= '0;
        end
      end

      if (out_fire) begin
        if (rd_ptr_q == LAST_PTR) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign out_data = mem_q[rd_ptr_q];
  // The exit cycle reports the final count before the register catches up.
  assign passes   = sort_done ? PW'(pass_q + 1'b1) : passes_q;

endmodule
